operand_loader: RTL

Sequential operand-capture stage that sits directly upstream of the ALU operation units (AND, OR, add, …). It collects operand A, operand B and an operation code, one per load strobe, from a shared narrow input bus. It then presents them as a stable, registered bundle with a valid/consume handshake. The ALU operation units are purely combinational, so this block is the only state holding their inputs.

---
 rtl/operand_loader_if.sv | 23 ++
 rtl/operand_loader.sv | 51 +++++
 2 files changed

// File: rtl/operand_loader_if.sv
// operand_loader_if: shared operand/opcode input bus and registered bundle with listo/consumido handshake
interface operand_loader_if #(
  parameter int M   = 4,
  parameter int OPW = 2
);
  logic [M-1:0]   dato_in;
  logic [OPW-1:0] op_in;
  logic           cargar;
  logic           consumido;
  logic [M-1:0]   expresionA;
  logic [M-1:0]   expresionB;
  logic [OPW-1:0] operacion;
  logic           listo;
  logic [1:0]     estado;
  modport master (
    output dato_in, op_in, cargar, consumido,
    input  expresionA, expresionB, operacion, listo, estado
  );
  modport slave (
    input  dato_in, op_in, cargar, consumido,
    output expresionA, expresionB, operacion, listo, estado
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: captures A, B, then opcode one per load event and holds them until consumed; LOAD_EDGE_EN makes loads rising-edge triggered
module operand_loader #(
  parameter int M   = 4,
  parameter int OPW = 2
) (
  input logic             clk,
  input logic             reset,
  operand_loader_if.slave bus
);
  localparam logic [1:0] CARGA_A  = 2'd0;
  localparam logic [1:0] CARGA_B  = 2'd1;
  localparam logic [1:0] CARGA_OP = 2'd2;
  localparam logic [1:0] LISTO    = 2'd3;
  logic [1:0]     r_state;
  logic [M-1:0]   r_a;
  logic [M-1:0]   r_b;
  logic [OPW-1:0] r_op;
  logic           r_listo;
  logic           w_load;
  logic [1:0]     w_next;
`ifdef LOAD_EDGE_EN
  logic r_cargar_q;
  always_ff @(posedge clk) r_cargar_q <= reset ? 1'b0 : bus.cargar;
  assign w_load = bus.cargar & ~r_cargar_q;
`else
  assign w_load = bus.cargar;
`endif
  // in LISTO a consume wins and any simultaneous load is dropped
  assign w_next = (r_state == LISTO) ? (bus.consumido ? CARGA_A : LISTO)
                                     : (w_load ? r_state + 2'd1 : r_state);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CARGA_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_listo <= 1'b0;
    end else begin
      if (w_load && r_state == CARGA_A) r_a <= bus.dato_in;
      if (w_load && r_state == CARGA_B) r_b <= bus.dato_in;
      if (w_load && r_state == CARGA_OP) r_op <= bus.op_in;
      r_state <= w_next;
      r_listo <= (w_next == LISTO);
    end
  end
  assign bus.expresionA = r_a;
  assign bus.expresionB = r_b;
  assign bus.operacion  = r_op;
  assign bus.listo      = r_listo;
  assign bus.estado     = r_state;
endmodule
